// File: rtl/seq_alu_if.sv
// seq_alu_if: operand/handshake bundle for the sequential ALU.
//   bus_in            operand source, sampled on a load
//   load_abar/bbar    active-low operand register loads
//   op, start         operation select and start strobe
//   enablebar         active-low output enable for the result driver
//   cout/zero/neg/ovf registered flags
//   busy, done        multiply-in-progress level, one-cycle completion pulse
// master: controller side, slave: ALU side.
interface seq_alu_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] bus_in;
   logic             load_abar;
   logic             load_bbar;
   logic [2:0]       op;
   logic             start;
   logic             enablebar;
   logic             cout;
   logic             zero;
   logic             neg;
   logic             ovf;
   logic             busy;
   logic             done;

   modport master (
      output bus_in, load_abar, load_bbar, op, start, enablebar,
      input  cout, zero, neg, ovf, busy, done
   );

   modport slave (
      input  bus_in, load_abar, load_bbar, op, start, enablebar,
      output cout, zero, neg, ovf, busy, done
   );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with A/B operand registers loaded from a shared bus,
// eight operations (add/sub/and/or/xor/inc/dec and a WIDTH-cycle shift-add
// multiply), registered result and flags, and an active-low tri-state
// result driver.
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   bus         seq_alu_if slave: bus_in, loads, op/start, enablebar,
//               flags, busy, done
//   alu_output  result register when enablebar=0, else high impedance
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   seq_alu_if.slave         bus,
   output wire [WIDTH-1:0]  alu_output
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_INC = 3'b101;
   localparam logic [2:0] OP_DEC = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   state_t                   r_state;
   logic signed [WIDTH-1:0]  r_a;
   logic signed [WIDTH-1:0]  r_b;
   logic [WIDTH-1:0]         r_result;
   logic                     r_cout;
   logic                     r_zero;
   logic                     r_neg;
   logic                     r_ovf;
   logic                     r_busy;
   logic                     r_done;
   logic [2*WIDTH-1:0]       r_mcand;
   logic [WIDTH-1:0]         r_mplier;
   logic [2*WIDTH-1:0]       r_acc;
   logic [CNT_W-1:0]         r_cnt;

   logic [WIDTH-1:0]         w_add_b;
   logic                     w_add_cin;
   logic [WIDTH:0]           w_sum;
   logic                     w_arith;
   logic [WIDTH-1:0]         w_alu_res;
   logic                     w_alu_cout;
   logic                     w_alu_ovf;
   logic [2*WIDTH-1:0]       w_acc_next;
   logic                     w_prod_hi_nz;

   // Two's-complement overflow: operands agree in sign, sum disagrees.
   function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                    input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

   // One shared adder serves ADD/SUB/INC/DEC; INC and DEC express their
   // implied +1 / -1 operand through carry-in and an all-ones operand.
   always_comb begin
      w_add_b   = r_b;
      w_add_cin = 1'b0;
      case (bus.op)
         OP_SUB: begin w_add_b = ~r_b;         w_add_cin = 1'b1; end
         OP_INC: begin w_add_b = '0;           w_add_cin = 1'b1; end
         OP_DEC: begin w_add_b = '1;           w_add_cin = 1'b0; end
         default: ;
      endcase
      w_sum   = {1'b0, r_a} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_add_cin};
      w_arith = (bus.op == OP_ADD) || (bus.op == OP_SUB) ||
                (bus.op == OP_INC) || (bus.op == OP_DEC);
      case (bus.op)
         OP_AND:  w_alu_res = r_a & r_b;
         OP_OR:   w_alu_res = r_a | r_b;
         OP_XOR:  w_alu_res = r_a ^ r_b;
         default: w_alu_res = w_sum[WIDTH-1:0];
      endcase
      w_alu_cout = w_arith & w_sum[WIDTH];
      w_alu_ovf  = w_arith & add_ovf(r_a[WIDTH-1], w_add_b[WIDTH-1],
                                     w_sum[WIDTH-1]);
   end

   // Shift-add step: accumulate the shifted multiplicand when the current
   // multiplier LSB is set.
   always_comb begin
      w_acc_next   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
      w_prod_hi_nz = |w_acc_next[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_zero   <= 1'b0;
         r_neg    <= 1'b0;
         r_ovf    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.op == OP_MUL) begin
                     r_mcand  <= {{WIDTH{1'b0}}, r_a};
                     r_mplier <= r_b;
                     r_acc    <= '0;
                     r_cnt    <= '0;
                     r_busy   <= 1'b1;
                     r_state  <= S_MUL;
                  end else begin
                     r_result <= w_alu_res;
                     r_cout   <= w_alu_cout;
                     r_ovf    <= w_alu_ovf;
                     r_zero   <= (w_alu_res == '0);
                     r_neg    <= w_alu_res[WIDTH-1];
                     r_done   <= 1'b1;
                     r_state  <= S_DONE;
                  end
               end
            end
            S_MUL: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + CNT_W'(1);
               // Final iteration: commit the completed product directly.
               if (r_cnt == CNT_W'(WIDTH - 1)) begin
                  r_result <= w_acc_next[WIDTH-1:0];
                  r_cout   <= w_prod_hi_nz;
                  r_ovf    <= w_prod_hi_nz;
                  r_zero   <= (w_acc_next[WIDTH-1:0] == '0);
                  r_neg    <= w_acc_next[WIDTH-1];
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
         // Operand loads are locked out while a multiply is in flight; an
         // op started on the same edge already captured the old values.
         if (r_state != S_MUL) begin
            if (!bus.load_abar) r_a <= bus.bus_in;
            if (!bus.load_bbar) r_b <= bus.bus_in;
         end
      end
   end

   assign bus.cout = r_cout;
   assign bus.zero = r_zero;
   assign bus.neg  = r_neg;
   assign bus.ovf  = r_ovf;
   assign bus.busy = r_busy;
   assign bus.done = r_done;

   assign alu_output = bus.enablebar ? {WIDTH{1'bz}} : r_result;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed bench for seq_alu (WIDTH=8) with hand-computed
// expected results and flags.
module tb_seq_alu;
   localparam int W = 8;

   logic         clk;
   logic         reset;
   wire [W-1:0]  alu_output;
   int           n_chk;
   int           n_fail;
   int           n_done;

   seq_alu_if #(.WIDTH(W)) bus_if ();

   seq_alu #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus_if),
      .alu_output (alu_output)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic load_a(input logic [W-1:0] v);
      bus_if.bus_in    = v;
      bus_if.load_abar = 1'b0;
      tick();
      bus_if.load_abar = 1'b1;
   endtask

   task automatic load_b(input logic [W-1:0] v);
      bus_if.bus_in    = v;
      bus_if.load_bbar = 1'b0;
      tick();
      bus_if.load_bbar = 1'b1;
   endtask

   // Start a single-cycle op; on return we are in the done cycle.
   task automatic start_op(input logic [2:0] op);
      bus_if.op    = op;
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
   endtask

   task automatic chk_res(input string tag, input logic [W-1:0] res,
                          input logic c, input logic z, input logic n,
                          input logic v);
      chk({tag, "_done"}, 32'(bus_if.done), 32'd1);
      chk({tag, "_res"},  32'(alu_output),  32'(res));
      chk({tag, "_cout"}, 32'(bus_if.cout), 32'(c));
      chk({tag, "_zero"}, 32'(bus_if.zero), 32'(z));
      chk({tag, "_neg"},  32'(bus_if.neg),  32'(n));
      chk({tag, "_ovf"},  32'(bus_if.ovf),  32'(v));
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      n_done = 0;
      reset            = 1'b1;
      bus_if.bus_in    = '0;
      bus_if.load_abar = 1'b1;
      bus_if.load_bbar = 1'b1;
      bus_if.op        = 3'b000;
      bus_if.start     = 1'b0;
      bus_if.enablebar = 1'b0;
      tick();
      tick();
      chk("rst_res",  32'(alu_output),  32'h0);
      chk("rst_zero", 32'(bus_if.zero), 32'h0);
      chk("rst_busy", 32'(bus_if.busy), 32'h0);
      chk("rst_done", 32'(bus_if.done), 32'h0);
      chk("rst_flags", 32'({bus_if.cout, bus_if.neg, bus_if.ovf}), 32'h0);
      reset = 1'b0;
      tick();

      // ADD / SUB basics
      load_a(8'd69);
      load_b(8'd7);
      start_op(3'b000);
      chk_res("add", 8'h4C, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("add_done_pulse", 32'(bus_if.done), 32'h0);
      start_op(3'b001);
      chk_res("sub", 8'h3E, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();

      // Negative result, signed overflow
      load_a(8'd30);
      load_b(8'd33);
      start_op(3'b001);
      chk_res("subneg", 8'hFD, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      load_a(8'h7F);
      load_b(8'h01);
      start_op(3'b000);
      chk_res("addovf", 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();

      // Logic ops on A=0x7F, B=0x01
      start_op(3'b010);
      chk_res("and", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      start_op(3'b011);
      chk_res("or", 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      start_op(3'b100);
      chk_res("xor", 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();

      // Tri-state output follows enablebar without a clock edge
      bus_if.enablebar = 1'b1;
      #1;
      chk("hiz", 32'(alu_output === 8'hzz), 32'd1);
      bus_if.enablebar = 1'b0;
      #1;
      chk("hiz_off", 32'(alu_output), 32'h7E);

      // Multiply 12*11 with a load pulse and a start attempt mid-operation
      load_a(8'd12);
      load_b(8'd11);
      start_op(3'b111);
      for (int i = 0; i < W; i++) begin
         chk($sformatf("mul_busy%0d", i), 32'({bus_if.busy, bus_if.done}),
             32'b10);
         bus_if.start     = (i == 2);
         bus_if.op        = (i == 2) ? 3'b000 : 3'b111;
         bus_if.load_abar = (i == 3) ? 1'b0 : 1'b1;
         bus_if.bus_in    = 8'h55;
         tick();
      end
      bus_if.start     = 1'b0;
      bus_if.load_abar = 1'b1;
      chk("mul_busy_end", 32'(bus_if.busy), 32'h0);
      chk_res("mul", 8'h84, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();

      // A must still be 12 after the blocked load: INC -> 13
      start_op(3'b101);
      chk_res("inc_lock", 8'h0D, 1'b0, 1'b0, 1'b0, 1'b0);
      // start while in DONE is ignored (XOR would give 0x07)
      bus_if.op    = 3'b100;
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
      chk("done_start_done", 32'(bus_if.done), 32'h0);
      chk("done_start_res",  32'(alu_output),  32'h0D);
      tick();
      chk("done_start_done2", 32'(bus_if.done), 32'h0);

      // Multiply with upper-half product: 0x20*0x10 = 0x200
      load_a(8'h20);
      load_b(8'h10);
      start_op(3'b111);
      repeat (W) tick();
      chk_res("mulovf", 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();

      // DEC from zero
      load_a(8'h00);
      start_op(3'b110);
      chk_res("dec0", 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();

      // Reset during the 4th multiply cycle aborts it
      load_a(8'd3);
      load_b(8'd5);
      start_op(3'b111);
      repeat (3) tick();
      chk("abort_busy_pre", 32'(bus_if.busy), 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_busy", 32'(bus_if.busy), 32'h0);
      chk("abort_res",  32'(alu_output),  32'h0);
      chk("abort_neg",  32'(bus_if.neg),  32'h0);
      for (int i = 0; i < 2 * W; i++) begin
         if (bus_if.done) n_done++;
         tick();
      end
      chk("abort_no_done", 32'(n_done), 32'h0);
      chk("abort_res_hold", 32'(alu_output), 32'h0);

      // INC wrap
      load_a(8'hFF);
      start_op(3'b101);
      chk_res("incwrap", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();

      // Same-edge load and start: op uses old A
      load_a(8'd5);
      load_b(8'd3);
      bus_if.bus_in    = 8'd9;
      bus_if.load_abar = 1'b0;
      start_op(3'b000);
      bus_if.load_abar = 1'b1;
      chk_res("same_edge", 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      start_op(3'b000);
      chk_res("same_edge_next", 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
